// File: rtl/lsu_pkg.sv
// Shared types for the load/store memory port: FSM states,
// access-size codes and a size helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RMW_RD = 2'd2,
        WR     = 2'd3
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Encoding 11 behaves as a word access.
    function automatic logic is_word(input logic [1:0] sz);
        return sz[1];
    endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// CPU-side request bundle and memory-side bus bundle for lsu_mem_port.
// Modports: master drives the transaction, slave responds.
interface lsu_req_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        misalign;

    modport master (
        output req, we, size, sext, addr, wdata,
        input  busy, done, rdata, misalign
    );
    modport slave (
        input  req, we, size, sext, addr, wdata,
        output busy, done, rdata, misalign
    );
endinterface

interface lsu_mem_if;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );
    modport slave (
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte/half lane extraction with extension for loads, and lane
// merge into the fetched word for read-modify-write stores.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [1:0]  b_lane;
    logic        h_lane;
    logic [4:0]  b_sh;
    logic [4:0]  h_sh;
    logic [31:0] b_word;
    logic [31:0] h_word;
    logic [7:0]  b_val;
    logic [15:0] h_val;

    // Big-endian numbering puts lane 0 in the top bits.
    assign b_lane = BIG_ENDIAN ? ~offset : offset;
    assign h_lane = BIG_ENDIAN ? ~offset[1] : offset[1];
    assign b_sh   = {b_lane, 3'b000};
    assign h_sh   = {h_lane, 4'b0000};
    assign b_word = word >> b_sh;
    assign h_word = word >> h_sh;
    assign b_val  = b_word[7:0];
    assign h_val  = h_word[15:0];

    always_comb begin
        load_data  = word;
        store_word = wdata;
        unique case (1'b1)
            (size == SZ_B): begin
                load_data  = {{24{sext & b_val[7]}}, b_val};
                store_word = (word & ~(32'h0000_00FF << b_sh))
                           | ({24'd0, wdata[7:0]} << b_sh);
            end
            (size == SZ_H): begin
                load_data  = {{16{sext & h_val[15]}}, h_val};
                store_word = (word & ~(32'h0000_FFFF << h_sh))
                           | ({16'd0, wdata[15:0]} << h_sh);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator for a word-wide memory without byte enables.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic      clk,
    input  logic      rst,
    lsu_req_if.slave  cpu,
    lsu_mem_if.master mem
);

    lsu_state_e  state_q;
    lsu_state_e  state_d;
    logic [31:0] addr_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        sext_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] mem_wdata_q;
    logic        done_q;
    logic        mis_q;
    logic        mis_req;
    logic [31:0] load_data;
    logic [31:0] store_word;

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis_req = ((cpu.size == SZ_H) & cpu.addr[0])
                   | (is_word(cpu.size) & (|cpu.addr[1:0]));
`else
    assign mis_req = 1'b0;
`endif

    lsu_lane_align #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_align (
        .word      (mem.mem_rdata),
        .offset    (addr_q[1:0]),
        .size      (size_q),
        .sext      (sext_q),
        .wdata     (wdata_q),
        .load_data (load_data),
        .store_word(store_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        cpu.busy   = (state_q != IDLE);
        mem.mem_we = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu.req && !mis_req) begin
                    if (!cpu.we)                 state_d = LOAD;
                    else if (is_word(cpu.size))  state_d = WR;
                    else                         state_d = RMW_RD;
                end
            end
            LOAD:   state_d = IDLE;
            RMW_RD: state_d = WR;
            WR: begin
                mem.mem_we = 1'b1;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q      <= '0;
            we_q        <= 1'b0;
            size_q      <= '0;
            sext_q      <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            mis_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cpu.req) begin
                        addr_q      <= cpu.addr;
                        we_q        <= cpu.we;
                        size_q      <= cpu.size;
                        sext_q      <= cpu.sext;
                        wdata_q     <= cpu.wdata;
                        mem_wdata_q <= cpu.wdata;
                        done_q      <= mis_req;
                        mis_q       <= mis_req;
                    end
                end
                LOAD: begin
                    rdata_q <= load_data;
                    done_q  <= 1'b1;
                end
                RMW_RD: mem_wdata_q <= store_word;
                WR:     done_q      <= 1'b1;
            endcase
        end
    end

    assign cpu.done      = done_q;
    assign cpu.misalign  = mis_q;
    assign cpu.rdata     = rdata_q;
    assign mem.mem_addr  = {addr_q[31:2], 2'b00};
    assign mem.mem_wdata = mem_wdata_q;

    // we_q is latched for completeness of the request record.
    logic unused_ok;
    assign unused_ok = we_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a small word-array memory model.
// Build with or without LSU_MISALIGN_TRAP_EN.
module tb_lsu_mem_port;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lsu_req_if cpu ();
    lsu_mem_if mem ();

    logic [31:0] mem_arr [0:63];

    assign mem.mem_rdata = mem_arr[mem.mem_addr[7:2]];

    always @(posedge clk)
        if (mem.mem_we) mem_arr[mem.mem_addr[7:2]] <= mem.mem_wdata;

    lsu_mem_port #(
        .BIG_ENDIAN(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cpu(cpu),
        .mem(mem)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int          cyc;
    int          n_we;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic        mis_seen;

    // Issue one access at a negedge and watch it until done.
    task automatic access(input logic st, input logic [1:0] sz,
                          input logic sx, input logic [31:0] a,
                          input logic [31:0] d, input logic hold);
        cyc      = 0;
        n_we     = 0;
        w_addr   = '0;
        w_data   = '0;
        mis_seen = 1'b0;
        cpu.req   = 1'b1;
        cpu.we    = st;
        cpu.size  = sz;
        cpu.sext  = sx;
        cpu.addr  = a;
        cpu.wdata = d;
        do begin
            @(negedge clk);
            cyc++;
            if (!hold) cpu.req = 1'b0;
            if (mem.mem_we) begin
                n_we++;
                w_addr = mem.mem_addr;
                w_data = mem.mem_wdata;
            end
        end while (!cpu.done && cyc < 10);
        mis_seen = cpu.misalign;
        cpu.req  = 1'b0;
        check("done_seen", {31'd0, cpu.done}, 32'd1);
    endtask

    int ab_we;
    int ab_done;

    initial begin
        for (int i = 0; i < 64; i++) mem_arr[i] <= '0;
        cpu.req   = 1'b1;
        cpu.we    = 1'b0;
        cpu.size  = SZ_W;
        cpu.sext  = 1'b0;
        cpu.addr  = 32'h10;
        cpu.wdata = '0;

        // 1: reset held with req asserted
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, cpu.busy}, 32'd0);
        check("rst_done", {31'd0, cpu.done}, 32'd0);
        check("rst_we", {31'd0, mem.mem_we}, 32'd0);
        check("rst_rdata", cpu.rdata, 32'd0);
        check("rst_maddr", mem.mem_addr, 32'd0);
        cpu.req = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        check("post_rst_busy", {31'd0, cpu.busy}, 32'd0);

        // 2: word store then word load
        access(1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        check("sw_cyc", cyc, 2);
        check("sw_nwe", n_we, 1);
        check("sw_addr", w_addr, 32'h10);
        check("sw_data", w_data, 32'hDEADBEEF);
        check("sw_mem", mem_arr[4], 32'hDEADBEEF);
        access(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 1'b0);
        check("lw_cyc", cyc, 2);
        check("lw_rdata", cpu.rdata, 32'hDEADBEEF);

        // 3: byte store through read-modify-write, req held high
        mem_arr[8] <= 32'h11223344;
        @(negedge clk);
        access(1'b1, SZ_B, 1'b0, 32'h23, 32'h000000AA, 1'b1);
        check("sb_cyc", cyc, 3);
        check("sb_nwe", n_we, 1);
        check("sb_data", w_data, 32'hAA223344);
        check("sb_rdata_kept", cpu.rdata, 32'hDEADBEEF);
        @(negedge clk);
        check("sb_no_requeue", {31'd0, cpu.busy}, 32'd0);
        check("sb_mem", mem_arr[8], 32'hAA223344);

        // 4: sub-word loads with extension
        mem_arr[8] <= 32'h0080FF7F;
        @(negedge clk);
        access(1'b0, SZ_B, 1'b1, 32'h21, 32'h0, 1'b0);
        check("lb", cpu.rdata, 32'hFFFFFFFF);
        access(1'b0, SZ_B, 1'b0, 32'h21, 32'h0, 1'b0);
        check("lbu", cpu.rdata, 32'h000000FF);
        access(1'b0, SZ_B, 1'b1, 32'h23, 32'h0, 1'b0);
        check("lb3", cpu.rdata, 32'h00000000);
        access(1'b0, SZ_H, 1'b1, 32'h20, 32'h0, 1'b0);
        check("lh", cpu.rdata, 32'hFFFFFF7F);
        access(1'b0, SZ_H, 1'b0, 32'h22, 32'h0, 1'b0);
        check("lhu", cpu.rdata, 32'h00000080);
        access(1'b0, 2'b11, 1'b1, 32'h20, 32'h0, 1'b0);
        check("lw_sz11", cpu.rdata, 32'h0080FF7F);
        access(1'b0, SZ_H, 1'b0, 32'h22, 32'h0, 1'b0);

        // 5: misaligned word load
        access(1'b0, SZ_W, 1'b0, 32'h22, 32'h0, 1'b0);
        check("mis_nwe", n_we, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_cyc", cyc, 1);
        check("mis_flag", {31'd0, mis_seen}, 32'd1);
        check("mis_rdata", cpu.rdata, 32'h00000080);
`else
        check("mis_cyc", cyc, 2);
        check("mis_flag", {31'd0, mis_seen}, 32'd0);
        check("mis_rdata", cpu.rdata, 32'h0080FF7F);
`endif
        @(negedge clk);
        check("mis_pulse", {31'd0, cpu.misalign}, 32'd0);

        // half store into the upper lane
        access(1'b1, SZ_H, 1'b0, 32'h22, 32'hCAFE1234, 1'b0);
        check("sh_cyc", cyc, 3);
        check("sh_data", w_data, 32'h1234FF7F);
        check("sh_mem", mem_arr[8], 32'h1234FF7F);

        // 6: reset while in RMW_RD abandons the store
        cpu.req   = 1'b1;
        cpu.we    = 1'b1;
        cpu.size  = SZ_H;
        cpu.addr  = 32'h20;
        cpu.wdata = 32'h0000BEEF;
        @(negedge clk);
        cpu.req = 1'b0;
        check("ab_busy", {31'd0, cpu.busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("ab_rst_busy", {31'd0, cpu.busy}, 32'd0);
        ab_we   = 0;
        ab_done = 0;
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (mem.mem_we) ab_we++;
            if (cpu.done)   ab_done++;
        end
        check("ab_nwe", ab_we, 0);
        check("ab_ndone", ab_done, 0);
        check("ab_mem", mem_arr[8], 32'h1234FF7F);
        check("ab_rdata", cpu.rdata, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
